// File: rtl/count_down_timer_pkg.sv
// Shared constants, FSM state type and input clamping helpers for the
// HH:MM:SS countdown timer.
package count_down_timer_pkg;

    localparam int unsigned TICK_DIV_DEFAULT = 100_000_000;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h99;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_RINGING = 2'd3
    } timer_state_e;

    // Minutes/seconds: anything numerically above the field maximum saturates.
    function automatic logic [7:0] clamp_ms(input logic [7:0] value, input logic [7:0] max_value);
        logic [7:0] result;
        if (value > max_value) begin
            result = max_value;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Hours: any non-decimal digit makes the whole field saturate to 99.
    function automatic logic [7:0] clamp_hour(input logic [7:0] value);
        logic [7:0] result;
        if ((value[7:4] > 4'd9) || (value[3:0] > 4'd9)) begin
            result = HOUR_MAX;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/count_down_timer_if.sv
// Control/preset inputs from the keypad side and BCD/ring outputs to the
// display side of the countdown timer.
interface count_down_timer_if;
    logic       set_timer;
    logic       reset_timer;
    logic       pause;
    logic [7:0] hour_bcd_in;
    logic [7:0] minute_bcd_in;
    logic [7:0] second_bcd_in;
    logic [7:0] hour_out_bcd;
    logic [7:0] minute_out_bcd;
    logic [7:0] second_out_bcd;
    logic       ring;

    modport master (
        output set_timer, reset_timer, pause,
        output hour_bcd_in, minute_bcd_in, second_bcd_in,
        input  hour_out_bcd, minute_out_bcd, second_out_bcd, ring
    );

    modport slave (
        input  set_timer, reset_timer, pause,
        input  hour_bcd_in, minute_bcd_in, second_bcd_in,
        output hour_out_bcd, minute_out_bcd, second_out_bcd, ring
    );
endinterface

// File: rtl/count_down_timer_bcd_sub1.sv
// Two-digit packed-BCD decrement by one. The units digit wraps 0 -> 9; the
// tens digit wraps 0 -> tens_max and raises borrow toward the next field.
module bcd_sub1_mod (
    input  logic [7:0] value_in,
    input  logic [3:0] tens_max,
    output logic [7:0] value_out,
    output logic       borrow
);

    // Digit-wise decrement with borrow between units and tens.
    always_comb begin
        value_out = value_in;
        borrow    = 1'b0;
        if (value_in[3:0] == 4'd0) begin
            value_out[3:0] = 4'd9;
            if (value_in[7:4] == 4'd0) begin
                value_out[7:4] = tens_max;
                borrow         = 1'b1;
            end else begin
                value_out[7:4] = value_in[7:4] - 4'd1;
                borrow         = 1'b0;
            end
        end else begin
            value_out[3:0] = value_in[3:0] - 4'd1;
            value_out[7:4] = value_in[7:4];
            borrow         = 1'b0;
        end
    end

endmodule

// File: rtl/count_down_timer.sv
// Settable HH:MM:SS countdown timer. Holds preset and remaining count in
// packed BCD, decrements once every TICK_DIV clocks while running and raises
// a sticky ring flag when the count reaches 00:00:00.
module count_down_timer
    import count_down_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    count_down_timer_if.slave   bus
);

    localparam int unsigned  TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    timer_state_e      state_r;
    logic [TICK_W-1:0] tick_r;
    logic              pause_q_r;
    logic              ring_r;
    logic [7:0]        hour_r;
    logic [7:0]        minute_r;
    logic [7:0]        second_r;
    logic [7:0]        preset_hour_r;
    logic [7:0]        preset_minute_r;
    logic [7:0]        preset_second_r;

    logic              pause_edge_s;
    logic              count_zero_s;
    logic [7:0]        sec_dec_s;
    logic [7:0]        min_dec_s;
    logic [7:0]        hour_dec_s;
    logic              sec_borrow_s;
    logic              min_borrow_s;
    logic              hour_borrow_s;
    logic [7:0]        minute_next_s;
    logic [7:0]        hour_next_s;
    logic              next_zero_s;
    logic [7:0]        set_hour_s;
    logic [7:0]        set_minute_s;
    logic [7:0]        set_second_s;

    assign pause_edge_s = bus.pause & ~pause_q_r;
    assign count_zero_s = ({hour_r, minute_r, second_r} == 24'h000000);

    assign set_hour_s   = clamp_hour(bus.hour_bcd_in);
    assign set_minute_s = clamp_ms(bus.minute_bcd_in, MIN_MAX);
    assign set_second_s = clamp_ms(bus.second_bcd_in, SEC_MAX);

    bcd_sub1_mod u_sec_sub (
        .value_in  (second_r),
        .tens_max  (SEC_MAX[7:4]),
        .value_out (sec_dec_s),
        .borrow    (sec_borrow_s)
    );

    bcd_sub1_mod u_min_sub (
        .value_in  (minute_r),
        .tens_max  (MIN_MAX[7:4]),
        .value_out (min_dec_s),
        .borrow    (min_borrow_s)
    );

    bcd_sub1_mod u_hour_sub (
        .value_in  (hour_r),
        .tens_max  (HOUR_MAX[7:4]),
        .value_out (hour_dec_s),
        .borrow    (hour_borrow_s)
    );

    // Ripple the seconds borrow into minutes, and the minutes borrow into hours.
    always_comb begin
        minute_next_s = minute_r;
        hour_next_s   = hour_r;
        if (sec_borrow_s) begin
            minute_next_s = min_dec_s;
            if (min_borrow_s) begin
                hour_next_s = hour_dec_s;
            end else begin
                hour_next_s = hour_r;
            end
        end else begin
            minute_next_s = minute_r;
            hour_next_s   = hour_r;
        end
    end

    // The decrement that lands on zero is the one that stops the run and rings.
    assign next_zero_s = ({hour_next_s, minute_next_s, sec_dec_s} == 24'h000000);

    // Run/ring FSM with tick counter, preset/count registers and pause edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            tick_r          <= '0;
            pause_q_r       <= 1'b0;
            ring_r          <= 1'b0;
            hour_r          <= 8'h00;
            minute_r        <= 8'h00;
            second_r        <= 8'h00;
            preset_hour_r   <= 8'h00;
            preset_minute_r <= 8'h00;
            preset_second_r <= 8'h00;
        end else begin
            pause_q_r <= bus.pause;
            if (bus.set_timer) begin
                preset_hour_r   <= set_hour_s;
                preset_minute_r <= set_minute_s;
                preset_second_r <= set_second_s;
                hour_r          <= set_hour_s;
                minute_r        <= set_minute_s;
                second_r        <= set_second_s;
                state_r         <= ST_IDLE;
                ring_r          <= 1'b0;
                tick_r          <= '0;
            end else if (bus.reset_timer) begin
                hour_r   <= preset_hour_r;
                minute_r <= preset_minute_r;
                second_r <= preset_second_r;
                state_r  <= ST_IDLE;
                ring_r   <= 1'b0;
                tick_r   <= '0;
            end else if (pause_edge_s) begin
                // Tick counter is left alone so a paused second resumes where it stopped.
                case (state_r)
                    ST_RUN: begin
                        state_r <= ST_PAUSED;
                    end
                    ST_IDLE, ST_PAUSED, ST_RINGING: begin
                        ring_r <= 1'b0;
                        if (count_zero_s) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        ring_r  <= 1'b0;
                    end
                endcase
            end else if (state_r == ST_RUN) begin
                if (tick_r == TICK_LAST) begin
                    tick_r   <= '0;
                    second_r <= sec_dec_s;
                    minute_r <= minute_next_s;
                    hour_r   <= hour_next_s;
                    if (next_zero_s) begin
                        state_r <= ST_RINGING;
                        ring_r  <= 1'b1;
                    end
                end else begin
                    tick_r <= tick_r + TICK_W'(1'b1);
                end
            end
        end
    end

    assign bus.hour_out_bcd   = hour_r;
    assign bus.minute_out_bcd = minute_r;
    assign bus.second_out_bcd = second_r;
    assign bus.ring           = ring_r;

endmodule

// File: tb/tb_count_down_timer.sv
// Scoreboard bench for count_down_timer: expected HH:MM:SS/ring values come
// from an integer-seconds model and are queued when stimulus is applied.
module tb_count_down_timer;

    localparam int unsigned TD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    count_down_timer_if ifc ();

    count_down_timer #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #1 clk = ~clk;

    typedef struct {
        string       name;
        logic [24:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [24:0] dut_val();
        return {ifc.hour_out_bcd, ifc.minute_out_bcd, ifc.second_out_bcd, ifc.ring};
    endfunction

    function automatic int to_sec(input logic [23:0] hms);
        return (int'(hms[23:20]) * 10 + int'(hms[19:16])) * 3600 +
               (int'(hms[15:12]) * 10 + int'(hms[11:8])) * 60 +
               (int'(hms[7:4]) * 10 + int'(hms[3:0]));
    endfunction

    function automatic logic [23:0] to_bcd(input int t);
        int hh, mm, ss;
        hh = t / 3600;
        mm = (t / 60) % 60;
        ss = t % 60;
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic push(input string name, input logic [23:0] hms, input logic r);
        exp_t e;
        e.name = name;
        e.v    = {hms, r};
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        @(negedge clk);
        ifc.hour_bcd_in   = h;
        ifc.minute_bcd_in = m;
        ifc.second_bcd_in = s;
        ifc.set_timer     = 1'b1;
        @(negedge clk);
        ifc.set_timer     = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        ifc.reset_timer = 1'b1;
        @(negedge clk);
        ifc.reset_timer = 1'b0;
    endtask

    task automatic pulse_pause();
        @(negedge clk);
        ifc.pause = 1'b1;
        @(negedge clk);
        ifc.pause = 1'b0;
    endtask

    // Bounded wait for any output change; reports cycles elapsed.
    task automatic wait_change(output int n, output bit timed_out);
        logic [24:0] prev;
        prev      = dut_val();
        n         = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 3 * TD + 4; i++) begin
            @(negedge clk);
            n++;
            if (dut_val() !== prev) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        exp_t e;
        logic [24:0] got;
        ifc.hour_bcd_in = 8'h12; ifc.minute_bcd_in = 8'h34; ifc.second_bcd_in = 8'h56;
        idle(3);
        push("reset_held", 24'h000000, 1'b0);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b", e.name, got[24:1], got[0], e.v[24:1], e.v[0]); end
        rst_n = 1'b1;
        push("reset_idle", 24'h000000, 1'b0);
        idle(20);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b", e.name, got[24:1], got[0], e.v[24:1], e.v[0]); end
    endtask

    task automatic test_load();
        exp_t e;
        logic [24:0] got;
        drive_set(8'h01, 8'h30, 8'h15);
        push("load_hold", 24'h013015, 1'b0);
        idle(50);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b", e.name, got[24:1], got[0], e.v[24:1], e.v[0]); end
    endtask

    task automatic test_countdown();
        exp_t e;
        logic [24:0] got;
        int n;
        bit to;
        int t0;
        t0 = to_sec(24'h013015);
        for (int k = 1; k <= 5; k++) push("run_dec", to_bcd(t0 - k), 1'b0);
        pulse_pause();
        for (int k = 1; k <= 5; k++) begin
            wait_change(n, to);
            got = dut_val(); e = exp_q.pop_front(); checks++;
            if (to || got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b timeout=%0d", e.name, got[24:1], got[0], e.v[24:1], e.v[0], to); end
            if (k == 1) begin
                checks++;
                if (n != TD) begin failures++; $display("FAIL start_latency: got %0d cycles need %0d", n, TD); end
            end
        end
        pulse_pause();
        push("paused_frozen", to_bcd(t0 - 5), 1'b0);
        idle(25);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b", e.name, got[24:1], got[0], e.v[24:1], e.v[0]); end
        // Resume: 11 more decrements walk 01:30:10 through the 01:30:00 -> 01:29:59 borrow.
        for (int k = 6; k <= 16; k++) push("resume_dec", to_bcd(t0 - k), 1'b0);
        pulse_pause();
        for (int k = 6; k <= 16; k++) begin
            wait_change(n, to);
            got = dut_val(); e = exp_q.pop_front(); checks++;
            if (to || got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b timeout=%0d", e.name, got[24:1], got[0], e.v[24:1], e.v[0], to); end
            if (k == 6) begin
                checks++;
                if (n != TD - 1) begin failures++; $display("FAIL resume_latency: got %0d cycles need %0d", n, TD - 1); end
            end
        end
    endtask

    task automatic test_reset_timer();
        exp_t e;
        logic [24:0] got;
        int n;
        bit to;
        pulse_reset();
        push("reload_preset", 24'h013015, 1'b0);
        idle(20);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b", e.name, got[24:1], got[0], e.v[24:1], e.v[0]); end
        push("restart_dec", 24'h013014, 1'b0);
        pulse_pause();
        wait_change(n, to);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (to || got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b timeout=%0d", e.name, got[24:1], got[0], e.v[24:1], e.v[0], to); end
        checks++;
        if (n != TD) begin failures++; $display("FAIL reload_tick_cleared: got %0d cycles need %0d", n, TD); end
    endtask

    task automatic test_expiry();
        exp_t e;
        logic [24:0] got;
        int n;
        bit to;
        drive_set(8'h00, 8'h00, 8'h05);
        for (int k = 1; k <= 5; k++) push("expire_dec", to_bcd(5 - k), (k == 5));
        pulse_pause();
        for (int k = 1; k <= 5; k++) begin
            wait_change(n, to);
            got = dut_val(); e = exp_q.pop_front(); checks++;
            if (to || got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b timeout=%0d", e.name, got[24:1], got[0], e.v[24:1], e.v[0], to); end
        end
        push("ring_sticky", 24'h000000, 1'b1);
        idle(20);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b", e.name, got[24:1], got[0], e.v[24:1], e.v[0]); end
        pulse_pause();
        push("pause_clears_ring", 24'h000000, 1'b0);
        idle(20);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b", e.name, got[24:1], got[0], e.v[24:1], e.v[0]); end
        // Ring again, then clear it with reset_timer.
        drive_set(8'h00, 8'h00, 8'h02);
        push("ring2_dec", 24'h000001, 1'b0);
        push("ring2_zero", 24'h000000, 1'b1);
        pulse_pause();
        for (int k = 0; k < 2; k++) begin
            wait_change(n, to);
            got = dut_val(); e = exp_q.pop_front(); checks++;
            if (to || got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b timeout=%0d", e.name, got[24:1], got[0], e.v[24:1], e.v[0], to); end
        end
        pulse_reset();
        push("reset_clears_ring", 24'h000002, 1'b0);
        idle(2);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b", e.name, got[24:1], got[0], e.v[24:1], e.v[0]); end
    endtask

    task automatic test_borrow_clamp();
        exp_t e;
        logic [24:0] got;
        int n;
        bit to;
        drive_set(8'h00, 8'h01, 8'h00);
        push("min_borrow", 24'h000059, 1'b0);
        pulse_pause();
        wait_change(n, to);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (to || got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b timeout=%0d", e.name, got[24:1], got[0], e.v[24:1], e.v[0], to); end
        drive_set(8'h10, 8'h00, 8'h00);
        push("hour_borrow", 24'h095959, 1'b0);
        pulse_pause();
        wait_change(n, to);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (to || got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b timeout=%0d", e.name, got[24:1], got[0], e.v[24:1], e.v[0], to); end
        drive_set(8'h00, 8'h00, 8'h75);
        push("clamp_sec", 24'h000059, 1'b0);
        idle(2);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b", e.name, got[24:1], got[0], e.v[24:1], e.v[0]); end
        drive_set(8'hA5, 8'h60, 8'h5A);
        push("clamp_all", 24'h995959, 1'b0);
        idle(2);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b", e.name, got[24:1], got[0], e.v[24:1], e.v[0]); end
        drive_set(8'h3C, 8'h00, 8'h00);
        push("clamp_hour_units", 24'h990000, 1'b0);
        idle(2);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b", e.name, got[24:1], got[0], e.v[24:1], e.v[0]); end
        pulse_reset();
        push("clamped_preset", 24'h990000, 1'b0);
        idle(2);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b", e.name, got[24:1], got[0], e.v[24:1], e.v[0]); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [24:0] got;
        int n;
        bit to;
        // set_timer outranks a simultaneous pause edge; the held pause gives no later edge.
        @(negedge clk);
        ifc.hour_bcd_in = 8'h00; ifc.minute_bcd_in = 8'h00; ifc.second_bcd_in = 8'h03;
        ifc.set_timer = 1'b1; ifc.pause = 1'b1;
        @(negedge clk);
        ifc.set_timer = 1'b0;
        idle(3);
        ifc.pause = 1'b0;
        push("set_over_pause", 24'h000003, 1'b0);
        idle(10);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b", e.name, got[24:1], got[0], e.v[24:1], e.v[0]); end
        @(negedge clk);
        ifc.reset_timer = 1'b1; ifc.pause = 1'b1;
        @(negedge clk);
        ifc.reset_timer = 1'b0; ifc.pause = 1'b0;
        push("reset_over_pause", 24'h000003, 1'b0);
        idle(10);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b", e.name, got[24:1], got[0], e.v[24:1], e.v[0]); end
        push("start_after", 24'h000002, 1'b0);
        pulse_pause();
        wait_change(n, to);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (to || got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b timeout=%0d", e.name, got[24:1], got[0], e.v[24:1], e.v[0], to); end
    endtask

    task automatic test_async_reset();
        exp_t e;
        logic [24:0] got;
        drive_set(8'h00, 8'h02, 8'h00);
        pulse_pause();
        idle(9);
        @(negedge clk);
        rst_n = 1'b0;
        push("rst_mid_run", 24'h000000, 1'b0);
        @(negedge clk);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b", e.name, got[24:1], got[0], e.v[24:1], e.v[0]); end
        rst_n = 1'b1;
        // Preset must also be cleared: reload and start both leave zero.
        pulse_reset();
        pulse_pause();
        push("rst_preset_cleared", 24'h000000, 1'b0);
        idle(15);
        got = dut_val(); e = exp_q.pop_front(); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s: got %h ring=%b need %h ring=%b", e.name, got[24:1], got[0], e.v[24:1], e.v[0]); end
    endtask

    initial begin
        ifc.set_timer     = 1'b0;
        ifc.reset_timer   = 1'b0;
        ifc.pause         = 1'b0;
        ifc.hour_bcd_in   = 8'h00;
        ifc.minute_bcd_in = 8'h00;
        ifc.second_bcd_in = 8'h00;
        test_reset();
        test_load();
        test_countdown();
        test_reset_timer();
        test_expiry();
        test_borrow_clamp();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
